// File: rtl/i2c_slave_responder.sv
// rtl/i2c_slave_responder.sv - I2C target with pointer-addressed register file
module i2c_slave_responder #(
  parameter logic [6:0] SLAVE_ADDRESS = 7'h50,
  parameter int         DATA_LENGTH   = 8,
  parameter int         REG_DEPTH     = 16,
  parameter int         SYNC_STAGES   = 2
) (
  input  logic                         pclk,
  input  logic                         areset,
  input  logic                         scl_i,
  input  logic                         sda_i,
  output logic                         sda_oe,
  output logic                         busy,
  output logic                         wr_valid,
  output logic [$clog2(REG_DEPTH)-1:0] wr_addr,
  output logic [DATA_LENGTH-1:0]       wr_data,
  output logic                         start_det,
  output logic                         stop_det
);
  localparam int AW = $clog2(REG_DEPTH);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_d, sda_d, scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_ev, stop_ev;

  logic [DATA_LENGTH-1:0] shift_q, shift_nxt, byte_in, mem_rd;
  logic [3:0]             bit_cnt, bit_cnt_nxt;
  logic                   ack_rise, ack_rise_nxt, rw, rw_nxt, mem_we, last_bit, addr_hit;
  logic [AW-1:0]          ptr, ptr_nxt, wr_addr_nxt;
  logic [DATA_LENGTH-1:0] wr_data_nxt;
  logic                   sda_oe_nxt, busy_nxt, wr_valid_nxt;
  logic [DATA_LENGTH-1:0] mem [REG_DEPTH];

  // Lines idle high, so synchronizers reset to 1 to avoid phantom edges
  always_ff @(posedge pclk or posedge areset) begin
    if (areset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  assign start_ev = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_ev  = scl_s & scl_d & ~sda_d & sda_s;

  assign byte_in  = {shift_q[DATA_LENGTH-2:0], sda_s};
  assign last_bit = scl_rise && (bit_cnt == 4'(DATA_LENGTH - 1));
  assign addr_hit = (byte_in[DATA_LENGTH-1 -: 7] == SLAVE_ADDRESS);
  assign mem_rd   = mem[ptr];

  // State register
  always_ff @(posedge pclk or posedge areset) begin
    if (areset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; bus conditions override bit-level progress
  always_comb begin
    state_nxt = state;
    if (start_ev) state_nxt = ADDR;
    else if (stop_ev) state_nxt = IDLE;
    else begin
      case (state)
        ADDR:     if (last_bit) state_nxt = addr_hit ? ADDR_ACK : IGNORE;
        ADDR_ACK: if (scl_fall && ack_rise) state_nxt = rw ? RD : PTR;
        PTR:      if (last_bit) state_nxt = PTR_ACK;
        PTR_ACK:  if (scl_fall && ack_rise) state_nxt = WR;
        WR:       if (last_bit) state_nxt = WR_ACK;
        WR_ACK:   if (scl_fall && ack_rise) state_nxt = WR;
        RD:       if (scl_fall && bit_cnt == 4'(DATA_LENGTH)) state_nxt = RD_ACK;
        RD_ACK: begin
          if (scl_rise && sda_s) state_nxt = IGNORE;
          else if (scl_fall && ack_rise) state_nxt = RD;
        end
        default: ;
      endcase
    end
  end

  // Output and datapath next values; ack_rise marks that the ACK clock went high
  always_comb begin
    shift_nxt    = shift_q;
    bit_cnt_nxt  = bit_cnt;
    ack_rise_nxt = ack_rise;
    rw_nxt       = rw;
    ptr_nxt      = ptr;
    sda_oe_nxt   = sda_oe;
    busy_nxt     = busy;
    wr_valid_nxt = 1'b0;
    wr_addr_nxt  = wr_addr;
    wr_data_nxt  = wr_data;
    mem_we       = 1'b0;
    if (start_ev) begin
      bit_cnt_nxt = '0;
      sda_oe_nxt  = 1'b0;
    end else if (stop_ev) begin
      sda_oe_nxt = 1'b0;
      busy_nxt   = 1'b0;
    end else begin
      case (state)
        ADDR, PTR, WR: begin
          if (scl_rise) begin
            shift_nxt   = byte_in;
            bit_cnt_nxt = bit_cnt + 4'd1;
          end
          if (last_bit) begin
            bit_cnt_nxt  = '0;
            ack_rise_nxt = 1'b0;
            if (state == ADDR) begin
              busy_nxt = addr_hit;
              rw_nxt   = byte_in[0];
            end else if (state == PTR) begin
              ptr_nxt = byte_in[AW-1:0];
            end else begin
              mem_we       = 1'b1;
              wr_valid_nxt = 1'b1;
              wr_addr_nxt  = ptr;
              wr_data_nxt  = byte_in;
              ptr_nxt      = ptr + AW'(1);
            end
          end
        end
        ADDR_ACK, PTR_ACK, WR_ACK: begin
          if (scl_rise) ack_rise_nxt = 1'b1;
          else if (scl_fall) begin
            if (!ack_rise) sda_oe_nxt = 1'b1;
            else if (state == ADDR_ACK && rw) begin
              sda_oe_nxt  = ~mem_rd[DATA_LENGTH-1];
              shift_nxt   = mem_rd << 1;
              bit_cnt_nxt = 4'd1;
            end else begin
              sda_oe_nxt  = 1'b0;
              bit_cnt_nxt = '0;
            end
          end
        end
        RD: begin
          if (scl_fall) begin
            if (bit_cnt == 4'(DATA_LENGTH)) begin
              sda_oe_nxt   = 1'b0;
              ack_rise_nxt = 1'b0;
            end else begin
              sda_oe_nxt  = ~shift_q[DATA_LENGTH-1];
              shift_nxt   = shift_q << 1;
              bit_cnt_nxt = bit_cnt + 4'd1;
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              ptr_nxt      = ptr + AW'(1);
              ack_rise_nxt = 1'b1;
            end
          end else if (scl_fall && ack_rise) begin
            sda_oe_nxt  = ~mem_rd[DATA_LENGTH-1];
            shift_nxt   = mem_rd << 1;
            bit_cnt_nxt = 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers; async reset drops SDA immediately
  always_ff @(posedge pclk or posedge areset) begin
    if (areset) begin
      shift_q   <= '0;
      bit_cnt   <= '0;
      ack_rise  <= 1'b0;
      rw        <= 1'b0;
      ptr       <= '0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      for (int i = 0; i < REG_DEPTH; i++) mem[i] <= '0;
    end else begin
      shift_q   <= shift_nxt;
      bit_cnt   <= bit_cnt_nxt;
      ack_rise  <= ack_rise_nxt;
      rw        <= rw_nxt;
      ptr       <= ptr_nxt;
      sda_oe    <= sda_oe_nxt;
      busy      <= busy_nxt;
      wr_valid  <= wr_valid_nxt;
      wr_addr   <= wr_addr_nxt;
      wr_data   <= wr_data_nxt;
      start_det <= start_ev;
      stop_det  <= stop_ev;
      if (mem_we) mem[ptr] <= byte_in;
    end
  end
endmodule

// File: tb/tb_i2c_slave_responder.sv
// tb/tb_i2c_slave_responder.sv - randomized bench with transaction-level register model
module tb_i2c_slave_responder;
  localparam int Q = 6;

  logic       pclk = 1'b0, areset = 1'b1, scl = 1'b1, sda_m = 1'b1;
  logic       sda_oe, busy, wr_valid, start_det, stop_det;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  wire        sda_line = sda_m & ~sda_oe;

  int n_vec = 0, n_err = 0;
  int n_start = 0, n_stop = 0;
  bit oe_seen = 0, busy_seen = 0;
  logic [3:0] got_a[$], exp_a[$];
  logic [7:0] got_d[$], exp_d[$];
  logic [7:0] ref_mem [16];
  int         ref_ptr;
  logic [7:0] dq[$];

  always #5 pclk = ~pclk;

  i2c_slave_responder dut (
    .pclk(pclk), .areset(areset), .scl_i(scl), .sda_i(sda_line),
    .sda_oe(sda_oe), .busy(busy), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_data(wr_data), .start_det(start_det), .stop_det(stop_det)
  );

  always @(negedge pclk) begin
    if (start_det) n_start++;
    if (stop_det) n_stop++;
    if (sda_oe) oe_seen = 1;
    if (busy) busy_seen = 1;
    if (wr_valid) begin
      got_a.push_back(wr_addr);
      got_d.push_back(wr_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic ref_reset();
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    ref_ptr = 0;
  endtask

  task automatic qtr();
    repeat (Q) @(negedge pclk);
  endtask

  task automatic bus_start();
    sda_m = 1; qtr(); scl = 1; qtr(); sda_m = 0; qtr(); scl = 0; qtr();
  endtask

  task automatic bus_stop();
    sda_m = 0; qtr(); scl = 1; qtr(); sda_m = 1; qtr();
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; qtr(); scl = 1; qtr(); qtr(); scl = 0; qtr();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic want_ack, input string tag);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1; qtr(); scl = 1; qtr();
    chk(tag, sda_oe, want_ack);
    qtr(); scl = 0; qtr();
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1; qtr(); scl = 1; qtr(); b[i] = sda_line; qtr(); scl = 0; qtr();
    end
    send_bit(nack);
  endtask

  task automatic check_writes();
    chk("wr_count", got_a.size(), exp_a.size());
    while (exp_a.size() > 0 && got_a.size() > 0) begin
      chk("wr_addr", got_a.pop_front(), exp_a.pop_front());
      chk("wr_data", got_d.pop_front(), exp_d.pop_front());
    end
    got_a.delete(); got_d.delete(); exp_a.delete(); exp_d.delete();
  endtask

  task automatic do_write(input logic [6:0] a, input logic [7:0] p, input logic [7:0] d[$]);
    bit hit;
    int s0, t0;
    hit = (a == 7'h50);
    s0 = n_start; t0 = n_stop;
    oe_seen = 0; busy_seen = 0;
    bus_start();
    send_byte({a, 1'b0}, hit, "addr_ack");
    if (hit) chk("busy_on", busy, 1);
    send_byte(p, hit, "ptr_ack");
    if (hit) ref_ptr = p % 16;
    foreach (d[i]) begin
      send_byte(d[i], hit, "data_ack");
      if (hit) begin
        exp_a.push_back(4'(ref_ptr));
        exp_d.push_back(d[i]);
        ref_mem[ref_ptr] = d[i];
        ref_ptr = (ref_ptr + 1) % 16;
      end
    end
    bus_stop(); qtr();
    chk("wr_busy_off", busy, 0);
    chk("wr_start_cnt", n_start - s0, 1);
    chk("wr_stop_cnt", n_stop - t0, 1);
    check_writes();
    if (!hit) begin
      chk("miss_oe", oe_seen, 0);
      chk("miss_busy", busy_seen, 0);
    end
  endtask

  task automatic do_read(input bit set_ptr, input logic [7:0] p, input int n);
    logic [7:0] b;
    int s0, t0;
    s0 = n_start; t0 = n_stop;
    bus_start();
    if (set_ptr) begin
      send_byte(8'hA0, 1, "rd_addrw_ack");
      send_byte(p, 1, "rd_ptr_ack");
      ref_ptr = p % 16;
      bus_start();
    end
    send_byte(8'hA1, 1, "rd_addr_ack");
    for (int i = 0; i < n; i++) begin
      recv_byte(i == n - 1, b);
      chk("rd_data", b, ref_mem[ref_ptr]);
      if (i != n - 1) ref_ptr = (ref_ptr + 1) % 16;
    end
    chk("nack_release", sda_oe, 0);
    bus_stop(); qtr();
    chk("rd_busy_off", busy, 0);
    chk("rd_start_cnt", n_start - s0, set_ptr ? 2 : 1);
    chk("rd_stop_cnt", n_stop - t0, 1);
    got_a.delete(); got_d.delete();
    chk("rd_no_write", 0, 0 + got_a.size());
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    int r, n;
    ref_reset();
    repeat (3) @(negedge pclk);
    chk("rst_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    areset = 0;
    repeat (4) @(negedge pclk);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_start_det", start_det, 0);
    chk("rst_stop_det", stop_det, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);

    dq = {8'h5A, 8'hC3};
    do_write(7'h50, 8'h03, dq);
    do_read(1, 8'h03, 2);

    dq = {8'hFF};
    do_write(7'h51, 8'h00, dq);

    dq = {8'h11, 8'h22};
    do_write(7'h50, 8'h0F, dq);
    do_read(1, 8'hFF, 2);

    bus_start();
    send_byte(8'hA0, 1, "ar_addrw_ack");
    send_byte(8'h05, 1, "ar_ptr_ack");
    bus_start();
    send_byte(8'hA1, 1, "ar_addr_ack");
    for (int i = 0; i < 4; i++) begin
      sda_m = 1; qtr(); scl = 1; qtr(); qtr(); scl = 0; qtr();
    end
    qtr();
    chk("ar_oe_before", sda_oe, 1);
    scl = 1; qtr();
    areset = 1;
    #1;
    chk("ar_oe_async", sda_oe, 0);
    chk("ar_busy", busy, 0);
    repeat (2) @(negedge pclk);
    areset = 0;
    scl = 0; qtr();
    ref_reset();
    do_read(0, 8'h00, 3);

    bus_start();
    send_byte(8'hA0, 1, "ab_addr_ack");
    send_byte(8'h07, 1, "ab_ptr_ack");
    ref_ptr = 7;
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    bus_stop(); qtr();
    chk("ab_busy_off", busy, 0);
    check_writes();
    dq = {8'h77};
    do_write(7'h50, 8'h08, dq);
    do_read(1, 8'h07, 2);

    for (int t = 0; t < 16; t++) begin
      r = $urandom_range(0, 3);
      n = $urandom_range(1, 3);
      if (r <= 1) begin
        dq.delete();
        for (int k = 0; k < n; k++) dq.push_back(8'($urandom));
        do_write(($urandom_range(0, 5) == 0) ? 7'($urandom) : 7'h50, 8'($urandom), dq);
      end else begin
        do_read(r == 2, 8'($urandom), n);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
